axi4_lite_write_slave: RTL
==========================

AXI4_LITE_WRITE_SLAVE -- requirements
Module: axi4_lite_write_slave

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports CLK and RST.
REQ-002 Parameters SHALL be (name, default, meaning):
- ADDR_BASE, 64'h8000_0000, lowest accepted address.
- ADDR_SIZE, 64'h0800_0000, size of the accepted window in bytes.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- CLK, in, 1, clock.
- RST, in, 1, synchronous active-high reset.
- AW_ADDR, in, 64, write address.
- AW_PROT, in, 3, protection type; ignored.
- AW_VALID, in, 1, address valid.
- AW_READY, out, 1, address ready.
- W_DATA, in, 64, write data.
- W_STRB, in, 8, byte strobes.
- W_VALID, in, 1, data valid.
- W_READY, out, 1, data ready.
- B_RESP, out, 2, write response.
- B_VALID, out, 1, response valid.
- B_READY, in, 1, response ready.
- MEM_WADDR, out, 64, backend address, 8-byte aligned (AW_ADDR with bits [2:0] cleared).
- MEM_WDATA, out, 64, backend data.
- MEM_WMASK, out, 8, backend byte mask, equal to the captured W_STRB.
- MEM_WEN, out, 1, one-cycle backend write strobe.

Function
REQ-004 The FSM SHALL have three states: IDLE, WRITE and RESP.
REQ-005 In IDLE, the AW and W channels SHALL be captured independently, each into its own one-entry holding register with a full flag.
REQ-006 AW_READY SHALL equal (state==IDLE && !aw_full).
REQ-007 W_READY SHALL equal (state==IDLE && !w_full).
REQ-008 Both ready signals SHALL be driven from registers only, with no combinational path from any VALID input.
REQ-009 The AW and W handshakes SHALL be accepted in either order or in the same cycle.
REQ-010 A captured channel's READY SHALL deassert the cycle after its handshake and SHALL stay low until the B handshake completes.
REQ-011 When both full flags are set, the FSM SHALL enter WRITE on the next edge.
REQ-012 In WRITE, the block SHALL pulse MEM_WEN for exactly one cycle with MEM_WADDR, MEM_WDATA and MEM_WMASK valid, then SHALL move to RESP.
REQ-013 If the captured W_STRB is 8'h00, MEM_WEN SHALL stay low in WRITE and the response SHALL still be issued.
REQ-014 In RESP, B_VALID SHALL be 1 and B_RESP SHALL be stable until B_READY is sampled high.
REQ-015 On the B handshake, both full flags SHALL clear, B_VALID SHALL drop, and the FSM SHALL return to IDLE, with the READYs asserting the following cycle.
REQ-016 Latency: if the last of the AW/W handshakes is in cycle T, MEM_WEN SHALL be high in T+1 and B_VALID SHALL be high from T+2.
REQ-017 While B_READY is held low, no new AW or W transfer SHALL be accepted, giving at most one outstanding transaction.
REQ-018 Without an address error, B_RESP SHALL be OKAY (2'b00).

Reset
REQ-019 While RST is high at a CLK edge, the block SHALL set: state IDLE, both full flags 0, AW_READY 0, W_READY 0, B_VALID 0, B_RESP 2'b00, MEM_WEN 0, and MEM_WADDR/MEM_WDATA/MEM_WMASK to 0.
REQ-020 AW_READY and W_READY SHALL assert in the first cycle after RST deasserts.
REQ-021 A reset during WRITE or RESP SHALL abort the transaction: no further MEM_WEN, and B_VALID low from the next cycle.

Configuration
REQ-022 When AXI_WSLAVE_ADDR_CHECK_EN is defined, an address outside [ADDR_BASE, ADDR_BASE+ADDR_SIZE) SHALL keep MEM_WEN low in WRITE and SHALL return B_RESP SLVERR (2'b10).
REQ-023 When AXI_WSLAVE_ADDR_CHECK_EN is undefined, every address SHALL be written, B_RESP SHALL always be OKAY, and the parameters SHALL be unused.

Structure
REQ-024 Shared package axi4_lite_pkg SHALL hold:
- the RESP_OKAY and RESP_SLVERR constants;
- the AXI data width (64) and strobe width (8);
- the write-slave state enum.
REQ-025 The one-entry holding register plus full flag SHALL be a sub-module, axi4_lite_chan_buf, instantiated once for AW and once for W.

Verification
REQ-026 Simultaneous handshakes: AW_ADDR=64'h8000_0010 and W_DATA=64'hDEAD_BEEF_0123_4567, W_STRB=8'hFF, in the same cycle T -> MEM_WEN in T+1 with MEM_WADDR=64'h8000_0010, then B_VALID with B_RESP=00 at T+2.
REQ-027 AW first, W three cycles later: AW_READY stays low after capture; MEM_WEN occurs exactly one cycle after the W handshake; exactly one write results.
REQ-028 W_STRB=8'h0F on a W-before-AW transfer -> MEM_WMASK=8'h0F; then W_STRB=8'h00 -> no MEM_WEN, but B_VALID/OKAY is still returned.
REQ-029 B_READY held low for 5 cycles -> B_VALID and B_RESP stable, AW_READY=W_READY=0, and a second AW_VALID is not accepted until the cycle after the B handshake.
REQ-030 With AXI_WSLAVE_ADDR_CHECK_EN: AW_ADDR=64'h0000_1000 -> no MEM_WEN, B_RESP=10. Without the macro, the same address -> a write with B_RESP=00.
REQ-031 RST asserted in the RESP cycle -> B_VALID=0 the next cycle, no MEM_WEN, and both READYs high one cycle after RST drops.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, bus widths and the write-slave state type.
package axi4_lite_pkg;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  localparam int unsigned AXI_DATA_W  = 64;
  localparam int unsigned AXI_STRB_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RESP  = 2'd2
  } wslave_state_t;

endpackage

// File: rtl/axi4_lite_chan_buf.sv
// One-entry holding register with full flag for a single AXI channel payload.
module axi4_lite_chan_buf #(
  parameter int unsigned W = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         full,
  output logic [W-1:0] q
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      full <= 1'b0;
      q    <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      q    <= d;
    end
  end

endmodule

// File: rtl/axi4_lite_write_slave.sv
// AXI4-Lite write slave: independent AW/W capture, one backend write strobe, then B response.
// Optional address window check enabled by defining AXI_WSLAVE_ADDR_CHECK_EN.
module axi4_lite_write_slave
  import axi4_lite_pkg::*;
#(
  parameter logic [63:0] ADDR_BASE = 64'h8000_0000,
  parameter logic [63:0] ADDR_SIZE = 64'h0800_0000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [63:0]           AW_ADDR,
  input  logic [2:0]            AW_PROT,
  input  logic                  AW_VALID,
  output logic                  AW_READY,
  input  logic [AXI_DATA_W-1:0] W_DATA,
  input  logic [AXI_STRB_W-1:0] W_STRB,
  input  logic                  W_VALID,
  output logic                  W_READY,
  output logic [1:0]            B_RESP,
  output logic                  B_VALID,
  input  logic                  B_READY,
  output logic [63:0]           MEM_WADDR,
  output logic [AXI_DATA_W-1:0] MEM_WDATA,
  output logic [AXI_STRB_W-1:0] MEM_WMASK,
  output logic                  MEM_WEN
);

  wslave_state_t state, state_next;
  logic aw_full, w_full, aw_ready_q, w_ready_q;
  logic aw_load, w_load, b_done;
  logic aw_full_next, w_full_next;
  logic addr_err;
  logic [63:0] aw_addr_q;
  logic [AXI_STRB_W+AXI_DATA_W-1:0] w_q;
  logic unused_prot;

  assign aw_load = AW_VALID && aw_ready_q;
  assign w_load  = W_VALID && w_ready_q;
  assign b_done  = (state == ST_RESP) && B_READY;

  // Look-ahead of the full flags lets WRITE start on the same edge as the last handshake.
  assign aw_full_next = !b_done && (aw_full || aw_load);
  assign w_full_next  = !b_done && (w_full || w_load);

  axi4_lite_chan_buf #(.W(64)) u_aw_buf (
    .CLK   (CLK),
    .RST   (RST),
    .load  (aw_load),
    .clear (b_done),
    .d     (AW_ADDR),
    .full  (aw_full),
    .q     (aw_addr_q)
  );

  axi4_lite_chan_buf #(.W(AXI_STRB_W + AXI_DATA_W)) u_w_buf (
    .CLK   (CLK),
    .RST   (RST),
    .load  (w_load),
    .clear (b_done),
    .d     ({W_STRB, W_DATA}),
    .full  (w_full),
    .q     (w_q)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (aw_full_next && w_full_next) state_next = ST_WRITE;
      ST_WRITE: state_next = ST_RESP;
      ST_RESP:  if (B_READY) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // READYs are flops holding (state==IDLE && !full) for the coming cycle, forced low in reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
    end else begin
      state      <= state_next;
      aw_ready_q <= (state_next == ST_IDLE) && !aw_full_next;
      w_ready_q  <= (state_next == ST_IDLE) && !w_full_next;
    end
  end

`ifdef AXI_WSLAVE_ADDR_CHECK_EN
  assign addr_err = (aw_addr_q < ADDR_BASE) || ((aw_addr_q - ADDR_BASE) >= ADDR_SIZE);
`else
  logic unused_cfg;
  assign addr_err   = 1'b0;
  assign unused_cfg = ^{ADDR_BASE, ADDR_SIZE, aw_addr_q[2:0]};
`endif

  assign unused_prot = ^AW_PROT;

  assign AW_READY  = aw_ready_q;
  assign W_READY   = w_ready_q;
  assign MEM_WADDR = {aw_addr_q[63:3], 3'b000};
  assign MEM_WDATA = w_q[AXI_DATA_W-1:0];
  assign MEM_WMASK = w_q[AXI_STRB_W+AXI_DATA_W-1:AXI_DATA_W];
  assign MEM_WEN   = (state == ST_WRITE) && (|MEM_WMASK) && !addr_err;
  assign B_VALID   = (state == ST_RESP);
  assign B_RESP    = (state == ST_RESP && addr_err) ? RESP_SLVERR : RESP_OKAY;

endmodule
